ras_ckpt: RTL and testbench
===========================

Name: ras_ckpt

Overview:
- Parametrised return address stack (RAS) for the front-end branch predictor.
- Circular stack of predicted return targets: pushed on calls, popped on returns.
- Exposes a pointer/count checkpoint that travels with each predicted branch. On a mispredict or flush, the checkpoint is restored in one cycle.
- Sits beside the BTB/GBPT in the fetch prediction stage. Replaces the fixed depth-8, non-recoverable RAS.

Parameters:
- RAS_DEPTH, 8: number of entries; power of 2, minimum 2.
- RAS_TARGET_WIDTH, 12: width of each stored target (low PC bits; upper bits come from the upper PC table).
- LOG_RAS_DEPTH, $clog2(RAS_DEPTH): pointer width (derived; do not override).

Ports:
- CLK  input  1  clock
- RST  input  1  asynchronous active-high reset
- push_valid  input  1  push push_target this cycle (call)
- push_target  input  RAS_TARGET_WIDTH  return address to push
- pop_valid  input  1  pop this cycle (return)
- pop_target  output  RAS_TARGET_WIDTH  predicted return target = entry[ptr-1], combinational from state
- ckpt_ptr  output  LOG_RAS_DEPTH  current top-of-stack pointer (next write slot), for checkpointing
- ckpt_count  output  LOG_RAS_DEPTH+1  current valid-entry count, for checkpointing
- restore_valid  input  1  restore the stack to a saved checkpoint
- restore_ptr  input  LOG_RAS_DEPTH  saved pointer
- restore_count  input  LOG_RAS_DEPTH+1  saved count
- empty  output  1  ckpt_count == 0
- full  output  1  ckpt_count == RAS_DEPTH

Behaviour:
- Reset (async, immediate):
  - All entries = 0, ptr = 0, count = 0.
  - pop_target = 0, empty = 1, full = 0.
- Storage: entry array, ptr register, count register. All updates happen on the rising CLK edge.
- Read: pop_target = entry[(ptr-1) mod RAS_DEPTH] at all times, zero latency. The consumer samples it in the same cycle it asserts pop_valid.
- Push only:
  - entry[ptr] <= push_target; ptr <= ptr+1 (wraps modulo RAS_DEPTH).
  - count <= min(count+1, RAS_DEPTH).
  - Full: the oldest entry is silently overwritten; count stays RAS_DEPTH.
- Pop only:
  - ptr <= ptr-1 (wraps); count <= max(count-1, 0).
  - Empty: the pointer still moves and pop_target returns stale data; count stays 0. There is no error signal.
- Push and pop in the same cycle (coroutine swap):
  - entry[ptr-1] <= push_target; ptr and count unchanged.
  - pop_target in that cycle is the old top.
- Restore:
  - ptr <= restore_ptr, count <= restore_count. Entries are untouched (base mode).
  - restore_valid has absolute priority: push_valid and pop_valid in the same cycle are ignored.
  - restore_count > RAS_DEPTH is illegal input; the design clamps it to RAS_DEPTH.
- Outputs ckpt_ptr, ckpt_count, empty and full reflect registered state; they update the cycle after the event.
- Reset asserted mid-stream overrides everything, including a same-cycle restore.

Optional Feature:
- Macro: RAS_CKPT_TOP_REPAIR_EN.
- When defined:
  - Adds output ckpt_top (RAS_TARGET_WIDTH) = pop_target, which is saved with the checkpoint.
  - Adds input restore_top (RAS_TARGET_WIDTH).
  - On restore_valid, the block also writes entry[(restore_ptr-1) mod RAS_DEPTH] <= restore_top. This repairs a top entry that a wrong-path push overwrote.
  - The next-cycle pop_target equals restore_top.
- When undefined: these ports do not exist and restore touches only ptr/count.

Test Plan:
- Reset, then push 0x101, 0x202, 0x303 on consecutive cycles -> ckpt_ptr=3, ckpt_count=3, pop_target=0x303. Pops then return 0x303, 0x202, 0x101, and empty=1 after the third pop.
- Push 9 distinct values 1..9 with RAS_DEPTH=8 -> full=1, count=8, ptr=1. Eight pops return 9,8,...,2. A ninth pop returns stale 9 (wrapped) with count held at 0.
- Stack holds 0x0AA, 0x0BB; push+pop of 0x0CC in the same cycle -> pop_target during that cycle=0x0BB; afterwards pop_target=0x0CC, count=2, ptr unchanged.
- Save checkpoint (ptr=2, count=2, top 0x0BB); then pop, and push 0x0EE on the wrong path; restore -> ptr=2, count=2.
  - With RAS_CKPT_TOP_REPAIR_EN: pop_target=0x0BB.
  - Without it: pop_target=0x0EE (corrupted top, as documented).
- restore_valid together with push_valid and pop_valid -> only the restore takes effect. Assert RST while the stack holds 5 entries -> count=0, ptr=0, pop_target=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ras_ckpt.sv
// Return address stack with single-cycle pointer/count checkpoint restore.
// Optional top-entry repair on restore is enabled by defining RAS_CKPT_TOP_REPAIR_EN.
module ras_ckpt #(
  parameter int RAS_DEPTH        = 8,
  parameter int RAS_TARGET_WIDTH = 12,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic [RAS_TARGET_WIDTH-1:0] pop_target,
  output logic [LOG_RAS_DEPTH-1:0]    ckpt_ptr,
  output logic [LOG_RAS_DEPTH:0]      ckpt_count,
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_ptr,
  input  logic [LOG_RAS_DEPTH:0]      restore_count,
`ifdef RAS_CKPT_TOP_REPAIR_EN
  output logic [RAS_TARGET_WIDTH-1:0] ckpt_top,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_top,
`endif
  output logic                        empty,
  output logic                        full
);

  localparam logic [LOG_RAS_DEPTH:0]   DEPTH_CNT = (LOG_RAS_DEPTH+1)'(RAS_DEPTH);
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE   = (LOG_RAS_DEPTH+1)'(1);
  localparam logic [LOG_RAS_DEPTH-1:0] PTR_ONE   = LOG_RAS_DEPTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] entry [RAS_DEPTH];
  logic [LOG_RAS_DEPTH-1:0]    ptr;
  logic [LOG_RAS_DEPTH-1:0]    top_idx;
  logic [LOG_RAS_DEPTH:0]      count;
  logic [LOG_RAS_DEPTH:0]      restore_count_clamped;

  // ptr is the next write slot, so the top of stack lives one below it (wrapping).
  assign top_idx    = ptr - PTR_ONE;
  assign pop_target = entry[top_idx];
  assign ckpt_ptr   = ptr;
  assign ckpt_count = count;
  assign empty      = (count == '0);
  assign full       = (count == DEPTH_CNT);
`ifdef RAS_CKPT_TOP_REPAIR_EN
  assign ckpt_top   = pop_target;
`endif

  assign restore_count_clamped = (restore_count > DEPTH_CNT) ? DEPTH_CNT : restore_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr   <= '0;
      count <= '0;
    end else if (restore_valid) begin
      ptr   <= restore_ptr;
      count <= restore_count_clamped;
    end else if (push_valid && !pop_valid) begin
      ptr <= ptr + PTR_ONE;
      if (count != DEPTH_CNT) count <= count + CNT_ONE;
    end else if (pop_valid && !push_valid) begin
      ptr <= ptr - PTR_ONE;
      if (count != '0) count <= count - CNT_ONE;
    end
  end

  // A simultaneous push and pop replaces the top in place (coroutine swap).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
    end else if (restore_valid) begin
`ifdef RAS_CKPT_TOP_REPAIR_EN
      entry[restore_ptr - PTR_ONE] <= restore_top;
`endif
    end else if (push_valid && pop_valid) begin
      entry[top_idx] <= push_target;
    end else if (push_valid) begin
      entry[ptr] <= push_target;
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed testbench for ras_ckpt with a per-cycle behavioural stack model.
// Builds with or without RAS_CKPT_TOP_REPAIR_EN.
module tb_ras_ckpt;

  localparam int D  = 8;
  localparam int W  = 12;
  localparam int LD = $clog2(D);

  logic          CLK = 1'b0;
  logic          RST;
  logic          push_valid;
  logic [W-1:0]  push_target;
  logic          pop_valid;
  logic [W-1:0]  pop_target;
  logic [LD-1:0] ckpt_ptr;
  logic [LD:0]   ckpt_count;
  logic          restore_valid;
  logic [LD-1:0] restore_ptr;
  logic [LD:0]   restore_count;
  logic [W-1:0]  restore_top;
  logic          empty;
  logic          full;
`ifdef RAS_CKPT_TOP_REPAIR_EN
  logic [W-1:0]  ckpt_top;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  int m_entry [D];
  int m_ptr   = 0;
  int m_count = 0;

  ras_ckpt #(.RAS_DEPTH(D), .RAS_TARGET_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .pop_target(pop_target),
    .ckpt_ptr(ckpt_ptr), .ckpt_count(ckpt_count),
    .restore_valid(restore_valid), .restore_ptr(restore_ptr),
    .restore_count(restore_count),
`ifdef RAS_CKPT_TOP_REPAIR_EN
    .ckpt_top(ckpt_top), .restore_top(restore_top),
`endif
    .empty(empty), .full(full)
  );

  always #5 CLK = ~CLK;

  function automatic int model_top();
    return m_entry[(m_ptr + D - 1) % D];
  endfunction

  // Model: the stack as a circular array with integer pointer and count.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < D; i++) m_entry[i] = 0;
      m_ptr   = 0;
      m_count = 0;
    end else if (restore_valid) begin
      m_ptr   = int'(restore_ptr);
      m_count = (int'(restore_count) > D) ? D : int'(restore_count);
`ifdef RAS_CKPT_TOP_REPAIR_EN
      m_entry[(int'(restore_ptr) + D - 1) % D] = int'(restore_top);
`endif
    end else if (push_valid && pop_valid) begin
      m_entry[(m_ptr + D - 1) % D] = int'(push_target);
    end else if (push_valid) begin
      m_entry[m_ptr] = int'(push_target);
      m_ptr   = (m_ptr + 1) % D;
      m_count = (m_count < D) ? m_count + 1 : D;
    end else if (pop_valid) begin
      m_ptr   = (m_ptr + D - 1) % D;
      m_count = (m_count > 0) ? m_count - 1 : 0;
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every negedge, outputs must match the model.
  always @(negedge CLK) begin
    if (started) begin
      check_output("model.pop_target", int'(pop_target), model_top());
      check_output("model.ckpt_ptr",   int'(ckpt_ptr),   m_ptr);
      check_output("model.ckpt_count", int'(ckpt_count), m_count);
      check_output("model.empty",      int'(empty),      int'(m_count == 0));
      check_output("model.full",       int'(full),       int'(m_count == D));
`ifdef RAS_CKPT_TOP_REPAIR_EN
      check_output("model.ckpt_top",   int'(ckpt_top),   model_top());
`endif
    end
  end

  task automatic apply_stimulus(input bit psh, input int tgt, input bit pp,
                                input bit rst_v, input int rptr, input int rcnt,
                                input int rtop);
    push_valid    = psh;
    push_target   = W'(tgt);
    pop_valid     = pp;
    restore_valid = rst_v;
    restore_ptr   = LD'(rptr);
    restore_count = (LD+1)'(rcnt);
    restore_top   = W'(rtop);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input int tgt);
    apply_stimulus(1, tgt, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic pop_expect(input string name, input int exp);
    apply_stimulus(0, 0, 1, 0, 0, 0, 0);
    check_output(name, int'(pop_target), exp);
    tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #12;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    started = 1;

    check_output("reset.count", int'(ckpt_count), 0);
    check_output("reset.ptr",   int'(ckpt_ptr),   0);
    check_output("reset.top",   int'(pop_target), 0);
    check_output("reset.empty", int'(empty),      1);
    check_output("reset.full",  int'(full),       0);

    push('h101); push('h202); push('h303);
    check_output("push3.ptr",   int'(ckpt_ptr),   3);
    check_output("push3.count", int'(ckpt_count), 3);
    check_output("push3.top",   int'(pop_target), 'h303);
    pop_expect("pop.1", 'h303);
    pop_expect("pop.2", 'h202);
    pop_expect("pop.3", 'h101);
    check_output("pop3.empty",  int'(empty), 1);

    do_reset();
    for (int v = 1; v <= 9; v++) push(v);
    check_output("wrap.full",  int'(full),       1);
    check_output("wrap.count", int'(ckpt_count), 8);
    check_output("wrap.ptr",   int'(ckpt_ptr),   1);
    for (int v = 9; v >= 2; v--) pop_expect("wrap.pop", v);
    check_output("wrap.empty", int'(empty), 1);
    pop_expect("wrap.stale", 9);
    check_output("wrap.count_held", int'(ckpt_count), 0);
    check_output("wrap.ptr_after",  int'(ckpt_ptr),   0);

    apply_stimulus(0, 0, 0, 1, 6, 15, 'h321);
    tick();
    check_output("clamp.count", int'(ckpt_count), 8);
    check_output("clamp.full",  int'(full),       1);

    do_reset();
    push('h0AA); push('h0BB);
    apply_stimulus(1, 'h0CC, 1, 0, 0, 0, 0);
    #1;
    check_output("swap.top_during", int'(pop_target), 'h0BB);
    tick();
    check_output("swap.top_after", int'(pop_target), 'h0CC);
    check_output("swap.count",     int'(ckpt_count), 2);
    check_output("swap.ptr",       int'(ckpt_ptr),   2);

    do_reset();
    push('h0AA); push('h0BB);
    check_output("ckpt.ptr",   int'(ckpt_ptr),   2);
    check_output("ckpt.count", int'(ckpt_count), 2);
    pop_expect("wrong.pop", 'h0BB);
    push('h0EE);
    apply_stimulus(0, 0, 0, 1, 2, 2, 'h0BB);
    tick();
    check_output("restore.ptr",   int'(ckpt_ptr),   2);
    check_output("restore.count", int'(ckpt_count), 2);
`ifdef RAS_CKPT_TOP_REPAIR_EN
    check_output("restore.top", int'(pop_target), 'h0BB);
`else
    check_output("restore.top", int'(pop_target), 'h0EE);
`endif

    apply_stimulus(1, 'h777, 1, 1, 5, 3, 'h456);
    tick();
    check_output("prio.ptr",   int'(ckpt_ptr),   5);
    check_output("prio.count", int'(ckpt_count), 3);
`ifdef RAS_CKPT_TOP_REPAIR_EN
    check_output("prio.top", int'(pop_target), 'h456);
`else
    check_output("prio.top", int'(pop_target), 0);
`endif

    do_reset();
    for (int v = 0; v < 5; v++) push('h50 + v);
    check_output("five.count", int'(ckpt_count), 5);
    apply_stimulus(1, 'h999, 0, 1, 3, 3, 'h111);
    RST = 1'b1;
    #1;
    check_output("async.count", int'(ckpt_count), 0);
    check_output("async.ptr",   int'(ckpt_ptr),   0);
    check_output("async.top",   int'(pop_target), 0);
    @(posedge CLK);
    #1;
    check_output("rst_over_restore.count", int'(ckpt_count), 0);
    check_output("rst_over_restore.ptr",   int'(ckpt_ptr),   0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    RST = 1'b0;
    push('h1F0);
    check_output("post_rst.top", int'(pop_target), 'h1F0);

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
